// File: rtl/aoc_pkg.sv
// Shared types and helpers for the puzzle-solver answer formatting path.
package aoc_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // ceil(width * log10(2)) in integer arithmetic; 0.30103 is exact enough for any practical width
  function automatic int unsigned dec_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    EMIT,
    DONE
  } fmt_state_t;

endpackage

// File: rtl/dabble_adjust.sv
// Double-dabble correction column: every BCD digit >= 5 gets +3 before the shift.
module dabble_adjust #(
  parameter int unsigned DIGITS = 20
) (
  input  logic [4*DIGITS-1:0] i_bcd,
  output logic [4*DIGITS-1:0] o_bcd
);

  always_comb begin
    o_bcd = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (i_bcd[4*d +: 4] >= 4'd5) begin
        o_bcd[4*d +: 4] = i_bcd[4*d +: 4] + 4'd3;
      end else begin
        o_bcd[4*d +: 4] = i_bcd[4*d +: 4];
      end
    end
  end

endmodule

// File: rtl/bin_to_ascii_dec.sv
// Serial binary-to-decimal formatter: double-dabble conversion, then streams
// ASCII digits MSD first with leading zeros suppressed.
module bin_to_ascii_dec
  import aoc_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DIGITS = dec_digits(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             start,
  output logic [7:0]       charOut,
  output logic             charOutValid,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BCD_W = 4 * DIGITS;

  fmt_state_t        r_state,  w_state_nxt;
  logic [WIDTH-1:0]  r_shift,  w_shift_nxt;
  logic [BCD_W-1:0]  r_bcd,    w_bcd_nxt;
  logic [CNT_W-1:0]  r_bitCnt, w_bitCnt_nxt;
  logic [IDX_W-1:0]  r_digIdx, w_digIdx_nxt;
  logic              r_seen,   w_seen_nxt;
  logic [7:0]        r_char,   w_char_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_busy,   w_busy_nxt;

  logic [BCD_W-1:0]  w_bcd_adj;
  logic [3:0]        w_digit;

  dabble_adjust #(.DIGITS(DIGITS)) u_adjust (
    .i_bcd (r_bcd),
    .o_bcd (w_bcd_adj)
  );

  assign w_digit = r_bcd[4*r_digIdx +: 4];

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bcd_nxt    = r_bcd;
    w_bitCnt_nxt = r_bitCnt;
    w_digIdx_nxt = r_digIdx;
    w_seen_nxt   = r_seen;
    w_char_nxt   = r_char;
    w_valid_nxt  = r_valid;
    w_done_nxt   = r_done;
    w_busy_nxt   = r_busy;

    unique case (r_state)
      IDLE, DONE: begin
        w_char_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = (r_state == DONE);
        w_busy_nxt  = 1'b0;
        if (start) begin
          w_shift_nxt  = value;
          w_bcd_nxt    = '0;
          w_bitCnt_nxt = CNT_W'(WIDTH - 1);
          w_done_nxt   = 1'b0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = CONVERT;
        end
      end

      CONVERT: begin
        w_bcd_nxt    = {w_bcd_adj[BCD_W-2:0], r_shift[WIDTH-1]};
        w_shift_nxt  = r_shift << 1;
        w_bitCnt_nxt = r_bitCnt - 1'b1;
        if (r_bitCnt == '0) begin
          w_digIdx_nxt = IDX_W'(DIGITS - 1);
          w_seen_nxt   = 1'b0;
          w_state_nxt  = EMIT;
        end
      end

      EMIT: begin
        // digit 0 is always shown so a zero value still prints "0"
        if (w_digit != 4'd0 || r_seen || r_digIdx == '0) begin
          w_char_nxt  = ASCII_ZERO + {4'h0, w_digit};
          w_valid_nxt = 1'b1;
          w_seen_nxt  = 1'b1;
        end else begin
          w_char_nxt  = '0;
          w_valid_nxt = 1'b0;
        end
        w_digIdx_nxt = r_digIdx - 1'b1;
        if (r_digIdx == '0) begin
          w_state_nxt = DONE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_bitCnt <= '0;
      r_digIdx <= '0;
      r_seen   <= 1'b0;
      r_char   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bcd    <= w_bcd_nxt;
      r_bitCnt <= w_bitCnt_nxt;
      r_digIdx <= w_digIdx_nxt;
      r_seen   <= w_seen_nxt;
      r_char   <= w_char_nxt;
      r_valid  <= w_valid_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign charOut      = r_char;
  assign charOutValid = r_valid;
  assign done         = r_done;
  assign busy         = r_busy;

endmodule

// File: tb/tb_bin_to_ascii_dec.sv
// Scoreboard bench for bin_to_ascii_dec: expected characters are queued at
// start time and a negedge monitor pops/compares each emitted character.
module tb_bin_to_ascii_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] value;
  logic        start;
  logic [7:0]  charOut;
  logic        charOutValid;
  logic        done;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  q[$];
  logic        prev_valid = 1'b0;

  bin_to_ascii_dec #(.WIDTH(64), .DIGITS(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .value        (value),
    .start        (start),
    .charOut      (charOut),
    .charOutValid (charOutValid),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  always @(negedge clk) begin
    logic [7:0] exp;
    if (charOutValid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_char: got %0h required none (t=%0t)", charOut, $time);
      end else begin
        exp = q.pop_front();
        check("char", charOut, exp);
      end
    end else begin
      check("idle_char_zero", charOut, 0);
    end
    if (prev_valid && busy) check("contiguous", charOutValid, 1);
    prev_valid = charOutValid;
  end

  task automatic run(input logic [63:0] v, input string s, input bit inject);
    int n;
    push_str(s);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 64'd999;
    check("start_done_low", done, 0);
    check("start_busy_high", busy, 1);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      if (inject && i == 10) begin
        start = 1'b1;
        value = 64'd5;
      end
      if (inject && i == 11) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    check("done_latency", n, 85);
    check("all_chars_seen", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_sticky", done, 1);
    check("busy_low_done", busy, 0);
    q.delete();
  endtask

  initial begin
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    #2;
    check("rst_charOut", charOut, 0);
    check("rst_valid", charOutValid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    #20 rst = 1'b0;

    run(64'd357, "357", 1'b0);
    run(64'd3121910778619, "3121910778619", 1'b0);
    run(64'd0, "0", 1'b0);
    run(64'hFFFF_FFFF_FFFF_FFFF, "18446744073709551615", 1'b0);
    run(64'd357, "357", 1'b1);
    run(64'd42, "42", 1'b0);

    // async reset mid-EMIT, right after the first character was consumed
    push_str("357");
    @(negedge clk);
    value = 64'd357;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #7;
      if (q.size() == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_first_char", found, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", charOutValid, 0);
    check("arst_done", done, 0);
    check("arst_busy", busy, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_valid", charOutValid, 0);
    check("arst_hold_done", done, 0);
    check("arst_hold_busy", busy, 0);
    #3 rst = 1'b0;
    run(64'd357, "357", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
